// File: rtl/mixer_pkg.sv
// Shared types and helpers for the voice mixer.
`include "constants.svh"
package mixer_pkg;

   localparam int MIXER_VOLUME_BITS = 8;
   localparam int SAT_W             = 64;

   typedef enum logic [2:0] {
      IDLE,
      SWEEP,
      DRAIN,
      SCALE,
      OUTPUT
   } mixer_state_t;

   typedef struct packed {
      logic valid;
      logic active;
   } voice_tag_t;

   // Clamp a signed value into the range of a signed width-bit number.
   function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] value,
                                                        input int unsigned width);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
      lo = ~hi;
      if (value > hi)      return hi;
      else if (value < lo) return lo;
      else                 return value;
   endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Control, oscillator and output signals between the mixer and its neighbours.
`include "constants.svh"
interface voice_mixer_if
   import mixer_pkg::*;
#(
   parameter int WIDTH     = 24,
   parameter int N_VOICES  = `N_OSCILLATORS,
   parameter int OUT_WIDTH = 24
);
   localparam int IDX_W = $clog2(N_VOICES + 1);

   logic                                sample_tick;
   logic [N_VOICES-1:0]                 voice_active;
   logic [MIXER_VOLUME_BITS-1:0]        master_volume;
   logic signed [WIDTH+`FIXED_POINT-1:0] osc_in;
   logic [IDX_W-1:0]                    index;
   logic                                osc_enable;
   logic signed [OUT_WIDTH-1:0]         sample_out;
   logic                                sample_valid;
   logic                                busy;
   logic                                overrun;

   modport master (
      output sample_tick, voice_active, master_volume, osc_in,
      input  index, osc_enable, sample_out, sample_valid, busy, overrun
   );

   modport slave (
      input  sample_tick, voice_active, master_volume, osc_in,
      output index, osc_enable, sample_out, sample_valid, busy, overrun
   );

endinterface

// File: rtl/constants.svh
// Global constants shared by the oscillator datapath and the mixer.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH
`define FIXED_POINT 16
`define N_OSCILLATORS 4
`endif

// File: rtl/sample_saturator.sv
// Combinational volume scaling, fixed-point shift and output clamp.
`include "constants.svh"
module sample_saturator
   import mixer_pkg::*;
#(
   parameter int ACC_W     = 43,
   parameter int OUT_WIDTH = 24
) (
   input  logic signed [ACC_W-1:0]                   acc,
   input  logic [MIXER_VOLUME_BITS-1:0]              volume,
   input  logic signed [ACC_W+MIXER_VOLUME_BITS:0]   shift_in,
   output logic signed [ACC_W+MIXER_VOLUME_BITS:0]   shift_out,
   output logic signed [OUT_WIDTH-1:0]               clamped
);
   localparam int PROD_W = ACC_W + MIXER_VOLUME_BITS + 1;

   logic signed [PROD_W-1:0] prod;

   // Volume is zero-extended so 255 stays positive in the signed product.
   assign prod      = PROD_W'(acc) * PROD_W'($signed({1'b0, volume}));
   assign shift_out = prod >>> (`FIXED_POINT + MIXER_VOLUME_BITS);
   assign clamped   = OUT_WIDTH'(saturate(SAT_W'(shift_in), OUT_WIDTH));

endmodule

// File: rtl/voice_mixer.sv
// Sweeps the shared oscillator over all voices each sample tick and mixes the results.
`include "constants.svh"
module voice_mixer
   import mixer_pkg::*;
#(
   parameter int WIDTH       = 24,
   parameter int N_VOICES    = `N_OSCILLATORS,
   parameter int OSC_LATENCY = 1,
   parameter int OUT_WIDTH   = 24
) (
   input logic         clk,
   input logic         rst,
   voice_mixer_if.slave bus
);
   localparam int IDX_W   = $clog2(N_VOICES + 1);
   localparam int ACC_W   = WIDTH + `FIXED_POINT + $clog2(N_VOICES) + 1;
   localparam int SHIFT_W = ACC_W + MIXER_VOLUME_BITS + 1;
   localparam int DRAIN_W = (OSC_LATENCY > 1) ? $clog2(OSC_LATENCY) : 1;
   localparam logic [IDX_W-1:0] PARK = IDX_W'(N_VOICES);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_VOICES - 1);

   mixer_state_t                   state;
   logic [IDX_W-1:0]               index_q;
   logic                           osc_enable_q;
   logic [N_VOICES-1:0]            active_q;
   logic [MIXER_VOLUME_BITS-1:0]   volume_q;
   logic signed [ACC_W-1:0]        acc;
   voice_tag_t [OSC_LATENCY:0]     tag_pipe;
   voice_tag_t                     issue;
   logic [DRAIN_W-1:0]             drain_cnt;
   logic signed [SHIFT_W-1:0]      shift_d;
   logic signed [SHIFT_W-1:0]      shift_q;
   logic signed [OUT_WIDTH-1:0]    clamped;
   logic signed [OUT_WIDTH-1:0]    sample_q;
   logic                           valid_q;
   logic                           busy_q;
   logic                           overrun_q;

   // Tag for the voice being issued at the coming edge; it rides the pipe to meet osc_in.
   always_comb begin
      // NOTE: defaults first so every path assigns issue and no latch is inferred.
      issue = '0;
      if (state == IDLE && bus.sample_tick) begin
         issue.valid  = 1'b1;
         issue.active = bus.voice_active[0];
      end else if (state == SWEEP && index_q != LAST) begin
         issue.valid  = 1'b1;
         issue.active = active_q[index_q + 1'b1];
      end
   end

   sample_saturator #(
      .ACC_W     (ACC_W),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_saturator (
      .acc       (acc),
      .volume    (volume_q),
      .shift_in  (shift_q),
      .shift_out (shift_d),
      .clamped   (clamped)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the tag pipe and accumulator are reset so an aborted sweep leaves no residue.
         state        <= IDLE;
         index_q      <= PARK;
         osc_enable_q <= 1'b0;
         active_q     <= '0;
         volume_q     <= '0;
         acc          <= '0;
         tag_pipe     <= '0;
         drain_cnt    <= '0;
         shift_q      <= '0;
         sample_q     <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         overrun_q    <= bus.sample_tick && (state != IDLE);
         valid_q      <= 1'b0;
         osc_enable_q <= issue.active;
         tag_pipe[0]  <= issue;
         for (int i = 1; i <= OSC_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
         if (tag_pipe[OSC_LATENCY].valid && tag_pipe[OSC_LATENCY].active)
            acc <= acc + ACC_W'(bus.osc_in);

         case (state)
            IDLE: begin
               if (bus.sample_tick) begin
                  active_q <= bus.voice_active;
                  volume_q <= bus.master_volume;
                  acc      <= '0;
                  index_q  <= '0;
                  busy_q   <= 1'b1;
                  state    <= SWEEP;
               end
            end
            SWEEP: begin
               if (index_q == LAST) begin
                  index_q   <= PARK;
                  drain_cnt <= '0;
                  state     <= (OSC_LATENCY == 0) ? SCALE : DRAIN;
               end else begin
                  index_q <= index_q + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_W'(OSC_LATENCY - 1)) state <= SCALE;
               else drain_cnt <= drain_cnt + 1'b1;
            end
            SCALE: begin
               shift_q <= shift_d;
               state   <= OUTPUT;
            end
            OUTPUT: begin
               sample_q <= clamped;
               valid_q  <= 1'b1;
               busy_q   <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.index        = index_q;
   assign bus.osc_enable   = osc_enable_q;
   assign bus.sample_out   = sample_q;
   assign bus.sample_valid = valid_q;
   assign bus.busy         = busy_q;
   assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: four voices, one-cycle oscillator latency, 16-bit output.
module tb_voice_mixer;
   localparam int N     = 4;
   localparam int WIDTH = 24;
   localparam int OW    = 16;
`ifdef FIXED_POINT
   localparam int FP = `FIXED_POINT;
`else
   localparam int FP = 16;
`endif
   localparam int OSC_W = WIDTH + FP;
   localparam int PARK_VAL = 7777;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   voice_val [N];

   always #5 clk = ~clk;

   voice_mixer_if #(.WIDTH(WIDTH), .N_VOICES(N), .OUT_WIDTH(OW)) bus ();

   voice_mixer #(
      .WIDTH       (WIDTH),
      .N_VOICES    (N),
      .OSC_LATENCY (1),
      .OUT_WIDTH   (OW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic signed [OSC_W-1:0] fx(input int v);
      logic signed [OSC_W-1:0] t;
      t = OSC_W'(v);
      return t <<< FP;
   endfunction

   // Oscillator model: one register stage from index to osc_in; parked index yields junk.
   always @(posedge clk) begin
      if (rst) bus.osc_in <= '0;
      else if (bus.index < 3'(N)) bus.osc_in <= fx(voice_val[bus.index]);
      else bus.osc_in <= fx(PARK_VAL);
   end

   task automatic check(input string tag, input logic signed [63:0] actual,
                        input logic signed [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic set_voices(input int v0, input int v1, input int v2, input int v3);
      voice_val[0] = v0; voice_val[1] = v1; voice_val[2] = v2; voice_val[3] = v3;
   endtask

   // Returns at the negedge after E0 with the tick already dropped.
   task automatic start_tick(input logic [N-1:0] mask, input logic [7:0] vol);
      @(negedge clk);
      bus.sample_tick   = 1'b1;
      bus.voice_active  = mask;
      bus.master_volume = vol;
      @(negedge clk);
      bus.sample_tick = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.sample_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_mix(input string tag, input logic [N-1:0] mask,
                          input logic [7:0] vol, input int expected);
      int n;
      start_tick(mask, vol);
      wait_valid(n);
      check({tag, " latency"}, n, 7);
      check({tag, " sample"}, bus.sample_out, expected);
   endtask

   // Full cycle-by-cycle check of one sweep starting from IDLE.
   task automatic run_sweep(input string tag, input logic [N-1:0] mask,
                            input logic [7:0] vol, input int expected);
      start_tick(mask, vol);
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s index E%0d", tag, k), bus.index, k);
         check($sformatf("%s enable E%0d", tag, k), bus.osc_enable, mask[k]);
         check($sformatf("%s busy E%0d", tag, k), bus.busy, 1);
         @(negedge clk);
      end
      check({tag, " parked E4"}, bus.index, N);
      check({tag, " enable E4"}, bus.osc_enable, 0);
      for (int k = 5; k <= 6; k++) begin
         @(negedge clk);
         check($sformatf("%s valid E%0d", tag, k), bus.sample_valid, 0);
         check($sformatf("%s busy E%0d", tag, k), bus.busy, 1);
      end
      @(negedge clk);
      check({tag, " valid E7"}, bus.sample_valid, 1);
      check({tag, " busy E7"}, bus.busy, 0);
      check({tag, " sample"}, bus.sample_out, expected);
      @(negedge clk);
      check({tag, " valid E8"}, bus.sample_valid, 0);
   endtask

   initial begin
      int n;
      int extra;
      bus.sample_tick   = 1'b0;
      bus.voice_active  = '0;
      bus.master_volume = '0;
      set_voices(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      check("rst index", bus.index, N);
      check("rst enable", bus.osc_enable, 0);
      check("rst sample", bus.sample_out, 0);
      check("rst valid", bus.sample_valid, 0);
      check("rst busy", bus.busy, 0);
      check("rst overrun", bus.overrun, 0);

      set_voices(1000, 1000, 1000, 1000);
      run_sweep("unity", 4'b1111, 8'd255, 3984);

      set_voices(500, 500, 500, 500);
      run_sweep("mask", 4'b0101, 8'd255, 996);

      set_voices(30000, 30000, 30000, 30000);
      run_mix("sat pos", 4'b1111, 8'd255, 32767);
      set_voices(-30000, -30000, -30000, -30000);
      run_mix("sat neg", 4'b1111, 8'd255, -32768);

      set_voices(1000, -3000, 500, 0);
      run_mix("mixed sign", 4'b1111, 8'd255, -1495);
      set_voices(1000, 1000, 1000, 1000);
      run_mix("zero vol", 4'b1111, 8'd0, 0);

      // Overrun three cycles in; mask and volume changes mid-sweep must not matter.
      start_tick(4'b1111, 8'd255);
      bus.voice_active  = '0;
      bus.master_volume = '0;
      repeat (2) @(negedge clk);
      bus.sample_tick = 1'b1;
      @(negedge clk);
      check("ovr pulse", bus.overrun, 1);
      bus.sample_tick = 1'b0;
      @(negedge clk);
      check("ovr drop", bus.overrun, 0);
      wait_valid(n);
      check("ovr latency", n, 3);
      check("ovr sample", bus.sample_out, 3984);
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.sample_valid) extra++;
      end
      check("ovr single valid", extra, 0);

      // Tick on the OUTPUT edge is an overrun; the next cycle's tick is accepted.
      start_tick(4'b1111, 8'd255);
      repeat (6) @(negedge clk);
      bus.sample_tick   = 1'b1;
      bus.master_volume = 8'd128;
      @(negedge clk);
      check("edge valid", bus.sample_valid, 1);
      check("edge overrun", bus.overrun, 1);
      check("edge sample", bus.sample_out, 3984);
      set_voices(100, 200, 300, 400);
      @(negedge clk);
      bus.sample_tick = 1'b0;
      check("edge accept busy", bus.busy, 1);
      check("edge accept index", bus.index, 0);
      check("edge accept ovr", bus.overrun, 0);
      wait_valid(n);
      check("edge latency", n, 7);
      check("edge sample2", bus.sample_out, 500);

      // Asynchronous reset mid-sweep.
      set_voices(2000, 2000, 2000, 2000);
      start_tick(4'b1111, 8'd255);
      repeat (2) @(negedge clk);
      check("abort index2", bus.index, 2);
      #2 rst = 1'b1;
      #1;
      check("abort park", bus.index, N);
      check("abort enable", bus.osc_enable, 0);
      check("abort sample", bus.sample_out, 0);
      check("abort busy", bus.busy, 0);
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.sample_valid) extra++;
      end
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.sample_valid) extra++;
      end
      check("abort no valid", extra, 0);
      set_voices(10, 20, 30, -5);
      run_mix("fresh", 4'b1111, 8'd255, 54);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
